// File: rtl/pocket_pkg.sv
// Shared types for the video pipeline: pixel word and the line-fetch FSM state.
package pocket_pkg;

    typedef logic [23:0] rgb_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        FETCH,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/video_line_buffer.sv
// Two-bank ping-pong line buffer: one write port, one registered read port with
// synchronous output clear (maps onto a block RAM with output-register reset).
module video_line_buffer
    import pocket_pkg::*;
#(
    parameter int DEPTH = 400,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic          wr_bank,
    input  logic [IW-1:0] wr_index,
    input  rgb_t          wr_data,
    input  logic          rd_bank,
    input  logic [IW-1:0] rd_index,
    input  logic          rd_clear,
    output rgb_t          rd_data
);
    localparam int AW = $clog2(2 * DEPTH);

    rgb_t mem [0:2*DEPTH-1];

    function automatic logic [AW-1:0] flat(input logic bank, input logic [IW-1:0] idx);
        return bank ? AW'(DEPTH) + AW'(idx) : AW'(idx);
    endfunction

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[flat(wr_bank, wr_index)] <= wr_data;
        end
        if (rd_clear) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[flat(rd_bank, rd_index)];
        end
    end

endmodule

// File: rtl/video_line_fetch.sv
// Line-prefetch controller sharing one framebuffer RAM between scan-out and host writes.
// Optional sticky underrun flag enabled by defining VIDEO_FETCH_UNDERRUN_EN.
//
// state | meaning
// IDLE  | no fetch in progress; host writes granted
// SETUP | row base computed, first read issued
// FETCH | one framebuffer read per cycle into the back bank
// DRAIN | last read word lands in the back bank
module video_line_fetch
    import pocket_pkg::*;
#(
    parameter int VISIBLE_WIDTH  = 400,
    parameter int VISIBLE_HEIGHT = 360,
    parameter int TOTAL_WIDTH    = 500,
    parameter int ADDR_WIDTH     = $clog2(VISIBLE_WIDTH * VISIBLE_HEIGHT)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              line_start,
    input  logic [$clog2(VISIBLE_HEIGHT)-1:0] y_index,
    input  logic                              y_index_valid,
    input  logic [$clog2(VISIBLE_WIDTH)-1:0]  x_index,
    input  logic                              x_index_valid,
    output rgb_t                              rgb_out,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic                              mem_rd,
    output logic                              mem_wr,
    output rgb_t                              mem_wdata,
    input  rgb_t                              mem_rdata,
    input  logic                              host_wr_valid,
    output logic                              host_wr_ready,
    input  logic [ADDR_WIDTH-1:0]             host_wr_addr,
    input  rgb_t                              host_wr_data,
    output logic                              underrun,
    input  logic                              underrun_clear
);
    localparam int XW = $clog2(VISIBLE_WIDTH);
    localparam int YW = $clog2(VISIBLE_HEIGHT);
    localparam logic [XW-1:0]         LAST_COL   = XW'(VISIBLE_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(VISIBLE_WIDTH);

    if (TOTAL_WIDTH < VISIBLE_WIDTH + 4) begin : g_bad_total_width
        $error("video_line_fetch: TOTAL_WIDTH too small for fetch plus host slots");
    end

    fetch_state_t          state;
    logic                  front;
    logic [YW-1:0]         row;
    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH-1:0] row_base;
    logic [XW-1:0]         col;
    logic [XW-1:0]         col_next;
    logic [XW-1:0]         col_d1;
    logic                  rd_d1;
    logic                  buf_rd_clear;

    assign host_wr_ready = (state == IDLE) && !line_start;
    assign row_base      = ADDR_WIDTH'(row) * ROW_STRIDE;
    assign col_next      = col + XW'(1);
    assign buf_rd_clear  = reset || !x_index_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            front     <= 1'b0;
            row       <= '0;
            base      <= '0;
            col       <= '0;
            col_d1    <= '0;
            rd_d1     <= 1'b0;
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            // A line_start kills the return-data write of an aborted read.
            rd_d1  <= mem_rd && !line_start;
            col_d1 <= col;
            mem_wr <= 1'b0;
            if (line_start) begin
                front  <= !front;
                row    <= y_index;
                mem_rd <= 1'b0;
                state  <= y_index_valid ? SETUP : IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (host_wr_valid) begin
                            mem_wr    <= 1'b1;
                            mem_addr  <= host_wr_addr;
                            mem_wdata <= host_wr_data;
                        end
                    end
                    SETUP: begin
                        base     <= row_base;
                        col      <= '0;
                        mem_addr <= row_base;
                        mem_rd   <= 1'b1;
                        state    <= FETCH;
                    end
                    FETCH: begin
                        if (col == LAST_COL) begin
                            mem_rd <= 1'b0;
                            state  <= DRAIN;
                        end else begin
                            col      <= col_next;
                            mem_addr <= base + ADDR_WIDTH'(col_next);
                        end
                    end
                    DRAIN: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    video_line_buffer #(
        .DEPTH (VISIBLE_WIDTH),
        .IW    (XW)
    ) u_line_buffer (
        .clk      (clk),
        .wr_en    (rd_d1),
        .wr_bank  (!front),
        .wr_index (col_d1),
        .wr_data  (mem_rdata),
        .rd_bank  (front),
        .rd_index (x_index),
        .rd_clear (buf_rd_clear),
        .rd_data  (rgb_out)
    );

`ifdef VIDEO_FETCH_UNDERRUN_EN
    logic abort;
    assign abort = line_start && (state != IDLE);

    // Set has priority over a coincident clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            underrun <= 1'b0;
        end else if (abort) begin
            underrun <= 1'b1;
        end else if (underrun_clear) begin
            underrun <= 1'b0;
        end
    end
`else
    logic unused_clear;
    assign unused_clear = underrun_clear;
    assign underrun     = 1'b0;
`endif

endmodule

// File: tb/tb_video_line_fetch.sv
// Scoreboard bench for video_line_fetch: drivers push expected RAM reads, writes,
// pixels and status; a negedge monitor pops and compares.
module tb_video_line_fetch;
    import pocket_pkg::*;

    localparam int VW = 400;
    localparam int VH = 360;
    localparam int AW = $clog2(VW * VH);
    localparam int XW = $clog2(VW);
    localparam int YW = $clog2(VH);
    localparam int MAX_CYC = 12000;
`ifdef VIDEO_FETCH_UNDERRUN_EN
    localparam bit UR_EN = 1'b1;
`else
    localparam bit UR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          line_start;
    logic [YW-1:0] y_index;
    logic          y_index_valid;
    logic [XW-1:0] x_index;
    logic          x_index_valid;
    rgb_t          rgb_out;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_wr;
    rgb_t          mem_wdata;
    rgb_t          mem_rdata = '0;
    logic          host_wr_valid;
    logic          host_wr_ready;
    logic [AW-1:0] host_wr_addr;
    rgb_t          host_wr_data;
    logic          underrun;
    logic          underrun_clear;

    video_line_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .line_start     (line_start),
        .y_index        (y_index),
        .y_index_valid  (y_index_valid),
        .x_index        (x_index),
        .x_index_valid  (x_index_valid),
        .rgb_out        (rgb_out),
        .mem_addr       (mem_addr),
        .mem_rd         (mem_rd),
        .mem_wr         (mem_wr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .host_wr_valid  (host_wr_valid),
        .host_wr_ready  (host_wr_ready),
        .host_wr_addr   (host_wr_addr),
        .host_wr_data   (host_wr_data),
        .underrun       (underrun),
        .underrun_clear (underrun_clear)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic rgb_t pat(int a);
        return {6'h2A, a[17:0]};
    endfunction

    // Framebuffer RAM model: one-cycle read latency, untouched words hold pat(addr).
    rgb_t ram [logic [AW-1:0]];
    always @(posedge clk) begin
        if (mem_wr === 1'b1) ram[mem_addr] = mem_wdata;
        if (mem_rd === 1'b1) mem_rdata <= ram.exists(mem_addr) ? ram[mem_addr] : pat(int'(mem_addr));
    end

    typedef struct { int cyc; logic [AW-1:0] addr; rgb_t data; } mem_exp_t;
    typedef struct { int cyc; rgb_t data; } pix_exp_t;
    typedef struct { int cyc; bit is_ur; bit val; } stat_exp_t;

    mem_exp_t  rd_q [$];
    mem_exp_t  wr_q [$];
    pix_exp_t  pix_q [$];
    stat_exp_t st_q [$];

    int checks = 0;
    int failures = 0;
    bit done = 1'b0;

    task automatic check_val(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    // Monitor: the only process that updates checks/failures.
    always @(negedge clk) begin
        while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
            check_val("rd_missed_cycle", 32'(cyc), 32'(rd_q[0].cyc));
            void'(rd_q.pop_front());
        end
        if (mem_rd === 1'b1) begin
            if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
                check_val("rd_addr", 32'(mem_addr), 32'(rd_q[0].addr));
                check_val("rd_wr_overlap", 32'(mem_wr), 32'(0));
                void'(rd_q.pop_front());
            end else begin
                check_val("rd_unexpected", 32'(mem_rd), 32'(0));
            end
        end
        while (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
            check_val("wr_missed_cycle", 32'(cyc), 32'(wr_q[0].cyc));
            void'(wr_q.pop_front());
        end
        if (mem_wr === 1'b1) begin
            if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
                check_val("wr_addr", 32'(mem_addr), 32'(wr_q[0].addr));
                check_val("wr_data", 32'(mem_wdata), 32'(wr_q[0].data));
                void'(wr_q.pop_front());
            end else begin
                check_val("wr_unexpected", 32'(mem_wr), 32'(0));
            end
        end
        for (int i = pix_q.size() - 1; i >= 0; i--) begin
            if (pix_q[i].cyc == cyc) check_val("rgb_out", 32'(rgb_out), 32'(pix_q[i].data));
            else if (pix_q[i].cyc < cyc) check_val("pix_missed_cycle", 32'(cyc), 32'(pix_q[i].cyc));
            if (pix_q[i].cyc <= cyc) pix_q.delete(i);
        end
        for (int i = st_q.size() - 1; i >= 0; i--) begin
            if (st_q[i].cyc == cyc) begin
                if (st_q[i].is_ur) check_val("underrun", 32'(underrun), 32'(st_q[i].val));
                else check_val("host_wr_ready", 32'(host_wr_ready), 32'(st_q[i].val));
            end else if (st_q[i].cyc < cyc) begin
                check_val("status_missed_cycle", 32'(cyc), 32'(st_q[i].cyc));
            end
            if (st_q[i].cyc <= cyc) st_q.delete(i);
        end
        if (cyc > MAX_CYC) check_val("timeout_cycle", 32'(cyc), 32'(MAX_CYC));
        if (done || cyc > MAX_CYC) begin
            check_val("rd_q_left", 32'(rd_q.size()), 32'(0));
            check_val("wr_q_left", 32'(wr_q.size()), 32'(0));
            check_val("pix_q_left", 32'(pix_q.size()), 32'(0));
            check_val("st_q_left", 32'(st_q.size()), 32'(0));
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_ready(int c, bit v);
        st_q.push_back('{c, 1'b0, v});
    endtask

    task automatic exp_ur(int c, bit v);
        st_q.push_back('{c, 1'b1, v});
    endtask

    task automatic exp_reads(int t0, int row, int n);
        for (int i = 0; i < n; i++) rd_q.push_back('{t0 + 2 + i, AW'(row * VW + i), '0});
    endtask

    task automatic start_line(int y, bit yv);
        line_start = 1'b1;
        y_index = YW'(y);
        y_index_valid = yv;
        tick();
        line_start = 1'b0;
        y_index_valid = 1'b0;
    endtask

    task automatic full_line(int y);
        int t;
        t = cyc;
        exp_reads(t, y, VW);
        exp_ready(t, 1'b0);
        exp_ready(t + 1, 1'b0);
        exp_ready(t + 2 + VW, 1'b0);
        exp_ready(t + 3 + VW, 1'b1);
        start_line(y, 1'b1);
    endtask

    // Skipped line swaps banks; the just-fetched row is then scanned out.
    task automatic swap_and_scan(int row, bit patch7);
        int t;
        t = cyc;
        exp_ready(t, 1'b0);
        exp_ready(t + 1, 1'b1);
        start_line(0, 1'b0);
        for (int i = 0; i < VW; i++) begin
            int a;
            rgb_t e;
            a = row * VW + i;
            e = (patch7 && a == 7) ? 24'h123456 : pat(a);
            x_index = XW'(i);
            x_index_valid = 1'b1;
            pix_q.push_back('{cyc + 1, e});
            tick();
        end
        x_index = XW'(5);
        x_index_valid = 1'b0;
        pix_q.push_back('{cyc + 1, 24'h0});
        tick();
        tick();
    endtask

    initial begin
        int t;
        int c;
        reset = 1'b1;
        line_start = 1'b0;
        y_index = '0;
        y_index_valid = 1'b0;
        x_index = '0;
        x_index_valid = 1'b0;
        host_wr_valid = 1'b0;
        host_wr_addr = '0;
        host_wr_data = '0;
        underrun_clear = 1'b0;
        repeat (3) tick();

        // Reset state
        reset = 1'b0;
        t = cyc;
        exp_ready(t, 1'b1);
        exp_ur(t, 1'b0);
        pix_q.push_back('{t, 24'h0});
        exp_ready(t + 1, 1'b1);
        repeat (2) tick();

        // Nominal fetch of row 5 (addresses 2000..2399), then scan it out
        full_line(5);
        repeat (VW + 5) tick();
        swap_and_scan(5, 1'b0);

        // Host write, then host_wr_valid held across a fetch of row 0
        c = cyc;
        host_wr_valid = 1'b1;
        host_wr_addr = AW'(7);
        host_wr_data = 24'h123456;
        exp_ready(c, 1'b1);
        wr_q.push_back('{c + 1, AW'(7), 24'h123456});
        tick();
        host_wr_addr = AW'(8);
        host_wr_data = 24'hABCDEF;
        t = cyc;
        full_line(0);
        while (cyc < t + VW + 3) tick();
        wr_q.push_back('{t + VW + 4, AW'(8), 24'hABCDEF});
        tick();
        host_wr_valid = 1'b0;
        repeat (3) tick();
        swap_and_scan(0, 1'b1);

        // Abort: row 10 interrupted at t+100 by row 20, clear coinciding with set
        t = cyc;
        exp_ready(t, 1'b0);
        exp_reads(t, 10, 99);
        start_line(10, 1'b1);
        while (cyc < t + 100) tick();
        exp_reads(t + 100, 20, VW);
        exp_ready(t + 100, 1'b0);
        exp_ur(t + 100, 1'b0);
        exp_ready(t + 101, 1'b0);
        exp_ur(t + 101, UR_EN);
        exp_ready(t + 102 + VW, 1'b0);
        exp_ready(t + 103 + VW, 1'b1);
        underrun_clear = 1'b1;
        start_line(20, 1'b1);
        underrun_clear = 1'b0;
        while (cyc < t + 105 + VW) tick();
        c = cyc;
        exp_ur(c, UR_EN);
        exp_ur(c + 1, 1'b0);
        underrun_clear = 1'b1;
        tick();
        underrun_clear = 1'b0;
        tick();
        swap_and_scan(20, 1'b0);

        // Reset mid-fetch at t+50
        t = cyc;
        exp_ready(t, 1'b0);
        exp_reads(t, 1, 49);
        start_line(1, 1'b1);
        while (cyc < t + 50) tick();
        reset = 1'b1;
        x_index = XW'(3);
        x_index_valid = 1'b1;
        pix_q.push_back('{t + 51, 24'h0});
        tick();
        reset = 1'b0;
        x_index_valid = 1'b0;
        exp_ready(t + 51, 1'b1);
        exp_ready(t + 52, 1'b1);
        exp_ur(t + 52, 1'b0);
        pix_q.push_back('{t + 52, 24'h0});
        repeat (6) tick();
        done = 1'b1;
    end

endmodule
